// File: rtl/trs80_mem_pkg.sv
// Shared types for the TRS-80 memory subsystem: arbiter FSM states, the
// loader write-buffer entry and the default RAM address width.
package trs80_mem_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        CPU_WR,
        LD_WR
    } arb_state_t;

    // One buffered loader write; the address field is sized for the default
    // RAM, so ADDR_W on the arbiter must not exceed ADDR_W_DEFAULT.
    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic [7:0]                data;
    } ld_entry_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter and its neighbours (Z80 memory decode,
// SPI file loader, RAM macro). The master modport is the arbiter, which owns
// the RAM port; the slave modport is the surrounding system.
interface ram_arbiter_if import trs80_mem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    logic              cpu_wait;
    // Loader side
    logic              ld_downloading;
    logic              ld_wr;
    logic [24:0]       ld_addr;
    logic [7:0]        ld_data;
    logic              ld_busy;
    logic              ld_overflow;
    logic              ld_oob;
    // RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_q;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_wait,
        input  ld_downloading, ld_wr, ld_addr, ld_data,
        output ld_busy, ld_overflow, ld_oob,
        output ram_addr, ram_din, ram_we,
        input  ram_q
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_wait,
        output ld_downloading, ld_wr, ld_addr, ld_data,
        input  ld_busy, ld_overflow, ld_oob,
        input  ram_addr, ram_din, ram_we,
        output ram_q
    );

endinterface

// File: rtl/ld_fifo.sv
// Synchronous FIFO buffering loader writes until the arbiter finds a free
// RAM slot. DEPTH must be a power of two so the pointers wrap naturally.
// A push while full is only legal together with a pop; the caller gates it.
module ld_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 24,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Entry storage, written at the tail on every accepted push.
    // NOTE: storage is deliberately left without reset; an entry is only
    // observed once count marks it valid, and a reset-free array maps onto
    // plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head/tail pointers and occupancy; reset flushes the buffer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port system RAM between the Z80 bus and the SPI file
// loader. Loader writes are buffered in ld_fifo and drained in slots the CPU
// leaves idle; the loader takes priority only when the buffer is nearly full.
// Optional build macro ARB_CPU_HOLD_EN: hold the CPU off the RAM for the
// whole download, until ld_busy falls.
module ram_arbiter import trs80_mem_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_LAT    = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.master bus
);

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   URGENT_CNT = CW'(FIFO_DEPTH - 1);
    localparam logic [1:0]      LAT_LAST   = 2'(RAM_LAT - 1);

    arb_state_t        state;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_din_q;
    logic              ram_we_q;
    logic              cpu_ack_q;
    logic [7:0]        dout_q;
    logic              dl_q;
    logic              overflow_q;
    logic              oob_q;

    ld_entry_t         push_entry;
    ld_entry_t         head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              in_range;
    logic              ld_busy;
    logic              cpu_hold;
    logic              cpu_ok;
    logic              ld_urgent;
    logic              rd_ack;

    ld_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ld_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (push_entry),
        .dout    (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_range   = (bus.ld_addr >> ADDR_W) == '0;
    assign push_entry = '{addr: ADDR_W_DEFAULT'(bus.ld_addr[ADDR_W-1:0]), data: bus.ld_data};
    // The drain slot pops in the same cycle it drives ram_we, so a push into a
    // full buffer during LD_WR still fits.
    assign pop        = (state == LD_WR);
    assign push       = bus.ld_wr & in_range & (~fifo_full | pop);
    assign ld_busy    = bus.ld_downloading | ~fifo_empty;
    assign ld_urgent  = fifo_count >= URGENT_CNT;

`ifdef ARB_CPU_HOLD_EN
    assign cpu_hold = ld_busy;
`else
    assign cpu_hold = 1'b0;
`endif

    // A read ack is presented while back in IDLE with cpu_req still high;
    // masking with the ack keeps that same request from being granted twice.
    assign cpu_ok = bus.cpu_req & ~cpu_ack_q & ~cpu_hold;
    assign rd_ack = cpu_ack_q & (state == IDLE);

    // Sticky drop flags: cleared when a new download starts, set on a drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            dl_q <= bus.ld_downloading;
            if (bus.ld_downloading && !dl_q) begin
                overflow_q <= 1'b0;
                oob_q      <= 1'b0;
            end
            if (bus.ld_wr && !in_range)                      oob_q      <= 1'b1;
            if (bus.ld_wr && in_range && fifo_full && !pop)  overflow_q <= 1'b1;
        end
    end

    // Arbiter FSM with registered RAM port and CPU ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ram_we_q  <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    lat_cnt   <= '0;
                    if (ld_urgent || (!cpu_ok && !fifo_empty)) begin
                        state      <= LD_WR;
                        ram_addr_q <= head.addr[ADDR_W-1:0];
                        ram_din_q  <= head.data;
                        ram_we_q   <= 1'b1;
                    end else if (cpu_ok) begin
                        ram_addr_q <= bus.cpu_addr;
                        ram_din_q  <= bus.cpu_din;
                        if (bus.cpu_we) begin
                            state     <= CPU_WR;
                            ram_we_q  <= 1'b1;
                            cpu_ack_q <= 1'b1;
                        end else begin
                            state <= CPU_RD;
                        end
                    end
                end
                CPU_RD: begin
                    ram_we_q <= 1'b0;
                    if (lat_cnt == LAT_LAST) begin
                        cpu_ack_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                CPU_WR: begin
                    ram_we_q  <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    state     <= IDLE;
                end
                LD_WR: begin
                    ram_we_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Last read data, held for the CPU until the next read completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else if (rd_ack) begin
            dout_q <= bus.ram_q;
        end
    end

    // In the read-ack cycle the RAM output is forwarded directly so the data
    // lines up with cpu_ack; afterwards the held copy is shown.
    assign bus.cpu_dout    = rd_ack ? bus.ram_q : dout_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_wait    = bus.cpu_req & ~cpu_ack_q;
    assign bus.ld_busy     = ld_busy;
    assign bus.ld_overflow = overflow_q;
    assign bus.ld_oob      = oob_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.ram_we      = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a table of CPU transactions followed by
// hand-timed loader, priority, overflow, range and reset sequences.
// A behavioural RAM with RAM_LAT cycles of read latency backs the RAM port.
module tb_ram_arbiter;

    localparam int ADDR_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_LAT    = 1;

    logic clk = 1'b0;
    logic reset_n;

    ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RAM_LAT    (RAM_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // RAM model
    logic [7:0] mem [0:65535];
    logic [7:0] q1;
    logic [7:0] q2;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        q1 <= mem[bus.ram_addr];
        q2 <= q1;
    end
    assign bus.ram_q = (RAM_LAT == 2) ? q2 : q1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_dout;
        int          exp_lat;
    } cpu_vec_t;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access; lat is the number of edges until cpu_ack, -1 on timeout.
    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] din,
                              output int lat, output logic [7:0] dout);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = addr;
        bus.cpu_din  = din;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.cpu_ack) begin
                lat = i;
                break;
            end
        end
        dout = bus.cpu_dout;
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (!bus.ld_busy && !bus.ram_we) break;
            tick();
        end
        check("drain_done", bus.ld_busy, 0);
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_vec_t   vecs [10];
        int         lat;
        logic [7:0] dout;

        vecs[0] = '{1'b1, 16'h4200, 8'hA5, 8'h00, 1};
        vecs[1] = '{1'b1, 16'h5000, 8'h5A, 8'h00, 1};
        vecs[2] = '{1'b1, 16'h5001, 8'h5B, 8'h00, 1};
        vecs[3] = '{1'b0, 16'h4200, 8'h00, 8'hA5, 1 + RAM_LAT};
        vecs[4] = '{1'b0, 16'h5001, 8'h00, 8'h5B, 1 + RAM_LAT};
        vecs[5] = '{1'b1, 16'hFFFF, 8'h3C, 8'h5B, 1};
        vecs[6] = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 1 + RAM_LAT};
        vecs[7] = '{1'b0, 16'h5000, 8'h00, 8'h5A, 1 + RAM_LAT};
        vecs[8] = '{1'b1, 16'h0000, 8'hC3, 8'h5A, 1};
        vecs[9] = '{1'b0, 16'h0000, 8'h00, 8'hC3, 1 + RAM_LAT};

        reset_n            = 1'b0;
        bus.cpu_req        = 1'b0;
        bus.cpu_we         = 1'b0;
        bus.cpu_addr       = '0;
        bus.cpu_din        = '0;
        bus.ld_downloading = 1'b0;
        bus.ld_wr          = 1'b0;
        bus.ld_addr        = '0;
        bus.ld_data        = '0;

        // ---- reset state ----
        #12;
        check("rst_ram_we",   bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_din",  bus.ram_din, 0);
        check("rst_cpu_ack",  bus.cpu_ack, 0);
        check("rst_cpu_dout", bus.cpu_dout, 0);
        check("rst_ovf",      bus.ld_overflow, 0);
        check("rst_oob",      bus.ld_oob, 0);
        check("rst_busy",     bus.ld_busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // ---- table-driven CPU transactions ----
        for (int v = 0; v < 10; v++) begin
            cpu_access(vecs[v].we, vecs[v].addr, vecs[v].din, lat, dout);
            check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
            tick();
        end
        check("dout_hold_after_read", bus.cpu_dout, 8'hC3);

        // ---- reset in the middle of a read ----
        begin : rst_mid
            int acks = 0;
            bus.cpu_req  = 1'b1;
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 16'h5000;
            tick();
            check("rstmid_in_cpu_rd", bus.cpu_ack, 0);
            reset_n     = 1'b0;
            bus.cpu_req = 1'b0;
            #1;
            check("rstmid_ram_addr", bus.ram_addr, 0);
            check("rstmid_cpu_dout", bus.cpu_dout, 0);
            check("rstmid_cpu_wait", bus.cpu_wait, 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                if (bus.cpu_ack) acks++;
            end
            reset_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (bus.cpu_ack) acks++;
            end
            check("rstmid_no_ack", acks, 0);
            cpu_access(1'b0, 16'h4200, 8'h00, lat, dout);
            check("rstmid_read_lat", lat, 1 + RAM_LAT);
            check("rstmid_read_dout", dout, 8'hA5);
            tick();
        end

        // ---- three back-to-back loader writes, CPU idle ----
        begin : ld_basic
            int   we_cyc[$];
            logic busy_at[16];
            for (int c = 0; c < 16; c++) begin
                if (bus.ram_we) we_cyc.push_back(c);
                busy_at[c]         = bus.ld_busy;
                bus.ld_wr          = (c < 3);
                bus.ld_addr        = 25'h4200 + 25'(c);
                bus.ld_data        = 8'(8'h11 * (c + 1));
                bus.ld_downloading = (c < 3);
                tick();
            end
            bus.ld_wr = 1'b0;
            check("ld_we_count", we_cyc.size(), 3);
            check("ld_we_first",  (we_cyc.size() > 0) ? we_cyc[0] : -1, 2);
            check("ld_we_second", (we_cyc.size() > 1) ? we_cyc[1] : -1, 4);
            check("ld_we_third",  (we_cyc.size() > 2) ? we_cyc[2] : -1, 6);
            check("ld_busy_last_pop", busy_at[6], 1);
            check("ld_busy_after_pop", busy_at[7], 0);
            check("ld_mem0", mem[16'h4200], 8'h11);
            check("ld_mem1", mem[16'h4201], 8'h22);
            check("ld_mem2", mem[16'h4202], 8'h33);
        end

        // ---- CPU reads against a nearly full loader buffer ----
        begin : urgent
            bus.cpu_req  = 1'b1;
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 16'h5000;
            bus.ld_wr    = 1'b1;
            bus.ld_addr  = 25'h6000;
            bus.ld_data  = 8'h61;
            tick();
            bus.ld_addr = 25'h6001;
            bus.ld_data = 8'h62;
            tick();
            check("urg_ack1", bus.cpu_ack, 1);
            check("urg_dout1", bus.cpu_dout, 8'h5A);
            bus.cpu_addr = 16'h5001;
            bus.ld_addr  = 25'h6002;
            bus.ld_data  = 8'h63;
            tick();
            check("urg_ld_slot1", bus.ram_we, 1);
            check("urg_wait", bus.cpu_wait, 1);
            bus.ld_addr = 25'h6003;
            bus.ld_data = 8'h64;
            tick();
            bus.ld_wr = 1'b0;
            begin
                int   lat2 = -1;
                logic we_at1 = 1'b0;
                for (int i = 1; i <= 20; i++) begin
                    tick();
                    if (i == 1) we_at1 = bus.ram_we;
                    if (bus.cpu_ack) begin
                        lat2 = i;
                        break;
                    end
                end
                check("urg_loader_wins", we_at1, 1);
                check("urg_ack2_delay", lat2, 4);
                check("urg_dout2", bus.cpu_dout, 8'h5B);
            end
            bus.cpu_req = 1'b0;
            wait_drain();
            check("urg_mem_first", mem[16'h6000], 8'h61);
            check("urg_mem_last",  mem[16'h6003], 8'h64);
        end

        // ---- loader faster than one write per two cycles ----
        begin : overflow
            int   we_cnt = 0;
            logic ovf_at[25];
            for (int c = 0; c < 25; c++) begin
                if (bus.ram_we) we_cnt++;
                ovf_at[c]          = bus.ld_overflow;
                bus.ld_wr          = (c < 8);
                bus.ld_addr        = 25'h7000 + 25'(c);
                bus.ld_data        = 8'(8'h70 + c);
                bus.ld_downloading = !(c == 20 || c == 21);
                tick();
            end
            bus.ld_wr = 1'b0;
            check("ovf_clear_before", ovf_at[7], 0);
            check("ovf_set", ovf_at[8], 1);
            check("ovf_sticky", ovf_at[22], 1);
            check("ovf_cleared_on_rise", ovf_at[23], 0);
            check("ovf_writes", we_cnt, 7);
            check("ovf_mem_kept", mem[16'h7006], 8'h76);
            check("ovf_no_oob", bus.ld_oob, 0);
        end

        // ---- out-of-range and top-of-range loader addresses ----
        begin : oob
            int   we_cnt = 0;
            logic oob_at[10];
            for (int c = 0; c < 10; c++) begin
                if (bus.ram_we) we_cnt++;
                oob_at[c]   = bus.ld_oob;
                bus.ld_wr   = (c == 0 || c == 2);
                bus.ld_addr = (c == 0) ? 25'h10000 : 25'h0FFFF;
                bus.ld_data = (c == 0) ? 8'hEE : 8'h99;
                tick();
            end
            bus.ld_wr = 1'b0;
            check("oob_before", oob_at[0], 0);
            check("oob_set", oob_at[1], 1);
            check("oob_sticky", oob_at[9], 1);
            check("oob_write_count", we_cnt, 1);
            check("oob_no_alias", mem[16'h0000], 8'hC3);
            check("oob_top_addr", mem[16'hFFFF], 8'h99);
            bus.ld_downloading = 1'b0;
            wait_drain();
        end

        // ---- CPU request during a download ----
`ifdef ARB_CPU_HOLD_EN
        begin : hold
            int acks = 0;
            int lat3 = -1;
            bus.ld_downloading = 1'b1;
            bus.cpu_req        = 1'b1;
            bus.cpu_we         = 1'b0;
            bus.cpu_addr       = 16'h4200;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (bus.cpu_ack) acks++;
            end
            check("hold_no_ack", acks, 0);
            check("hold_wait", bus.cpu_wait, 1);
            bus.ld_downloading = 1'b0;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (bus.cpu_ack) begin
                    lat3 = i;
                    break;
                end
            end
            check("hold_release_lat", lat3, 1 + RAM_LAT);
            check("hold_dout", bus.cpu_dout, 8'h11);
            bus.cpu_req = 1'b0;
            tick();
        end
`else
        bus.ld_downloading = 1'b1;
        cpu_access(1'b0, 16'h4200, 8'h00, lat, dout);
        check("dl_interleave_lat", lat, 1 + RAM_LAT);
        check("dl_interleave_dout", dout, 8'h11);
        bus.ld_downloading = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
